// File: rtl/apb_master_if_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_if_if
//  Purpose  : Bundles the local request/response handshake and the APB bus
//             lines of the APB initiator. The master modport is the
//             initiator's view; the slave modport is the view of the
//             environment around it (local requester plus APB target).
//  Revision : 1.0 - initial release
// ============================================================================
interface apb_master_if_if #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32
);
    // Local request channel
    logic                          req_valid_in;
    logic                          req_ready_out;
    logic [APB_ADDR_WIDTH-1:0]     req_addr_in;
    logic                          req_write_in;
    logic [APB_DATA_WIDTH-1:0]     req_wdata_in;
    logic [APB_DATA_WIDTH/8-1:0]   req_strb_in;
    logic [2:0]                    req_prot_in;

    // Local response channel
    logic                          resp_valid_out;
    logic [APB_DATA_WIDTH-1:0]     resp_rdata_out;
    logic                          resp_error_out;

    // APB bus
    logic [APB_ADDR_WIDTH-1:0]     apb_addr_out;
    logic                          apb_psel_out;
    logic                          apb_penable_out;
    logic                          apb_write_out;
    logic [APB_DATA_WIDTH-1:0]     apb_wdata_out;
    logic [APB_DATA_WIDTH/8-1:0]   apb_strb_out;
    logic [2:0]                    apb_prot_out;
    logic [APB_DATA_WIDTH-1:0]     apb_rdata_in;
    logic                          apb_ready_in;
    logic                          apb_slverr_in;

    modport master (
        input  req_valid_in, req_addr_in, req_write_in, req_wdata_in,
               req_strb_in, req_prot_in,
               apb_rdata_in, apb_ready_in, apb_slverr_in,
        output req_ready_out,
               resp_valid_out, resp_rdata_out, resp_error_out,
               apb_addr_out, apb_psel_out, apb_penable_out, apb_write_out,
               apb_wdata_out, apb_strb_out, apb_prot_out
    );

    modport slave (
        output req_valid_in, req_addr_in, req_write_in, req_wdata_in,
               req_strb_in, req_prot_in,
               apb_rdata_in, apb_ready_in, apb_slverr_in,
        input  req_ready_out,
               resp_valid_out, resp_rdata_out, resp_error_out,
               apb_addr_out, apb_psel_out, apb_penable_out, apb_write_out,
               apb_wdata_out, apb_strb_out, apb_prot_out
    );
endinterface
`default_nettype wire

// File: rtl/apb_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_if
//  Purpose  : APB initiator. Takes one read/write request at a time over a
//             valid/ready handshake, runs SETUP/ACCESS on the APB bus and
//             returns a single-cycle response carrying read data and an error
//             flag. Each ACCESS phase is bounded by a PREADY timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_master_if #(
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLE  = 16
) (
    input  logic            apb_clk_in,
    input  logic            apb_rstn_in,
    apb_master_if_if.master bus
);

    localparam int STRB_WIDTH   = APB_DATA_WIDTH / 8;
    // A zero timeout still needs a legal one-bit counter vector.
    localparam int CNT_WIDTH    = (TIMEOUT_CYCLE > 0) ? $clog2(TIMEOUT_CYCLE + 1) : 1;
    localparam int CNT_LAST_INT = (TIMEOUT_CYCLE > 0) ? (TIMEOUT_CYCLE - 1) : 0;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(CNT_LAST_INT);
    localparam bit   TIMEOUT_EN = (TIMEOUT_CYCLE > 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                    state_q,       state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q,        addr_d;
    logic                      write_q,       write_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q,       wdata_d;
    logic [STRB_WIDTH-1:0]     strb_q,        strb_d;
    logic [2:0]                prot_q,        prot_d;
    logic                      psel_q,        psel_d;
    logic                      penable_q,     penable_d;
    logic                      resp_valid_q,  resp_valid_d;
    logic [APB_DATA_WIDTH-1:0] resp_rdata_q,  resp_rdata_d;
    logic                      resp_error_q,  resp_error_d;
    logic [CNT_WIDTH-1:0]      cnt_q,         cnt_d;

    // State and output registers; reset aborts any transfer without a response.
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            strb_q       <= '0;
            prot_q       <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            strb_q       <= strb_d;
            prot_q       <= prot_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state and next-output logic; bus fields hold unless a request is accepted.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        strb_d       = strb_q;
        prot_d       = prot_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_in) begin
                    addr_d    = bus.req_addr_in;
                    write_d   = bus.req_write_in;
                    // Reads present zero write data and strobes on the bus.
                    wdata_d   = bus.req_write_in ? bus.req_wdata_in : '0;
                    strb_d    = bus.req_write_in ? bus.req_strb_in  : '0;
                    prot_d    = bus.req_prot_in;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (bus.apb_ready_in) begin
                    // PREADY takes priority over a timeout in the same cycle.
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_error_d = bus.apb_slverr_in;
                    resp_rdata_d = (!write_q && !bus.apb_slverr_in) ? bus.apb_rdata_in : '0;
                    state_d      = ST_IDLE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                    resp_rdata_d = '0;
                    state_d      = ST_IDLE;
                end else if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                    // Saturate rather than wrap when the timeout is disabled.
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready_out   = (state_q == ST_IDLE);
    assign bus.resp_valid_out  = resp_valid_q;
    assign bus.resp_rdata_out  = resp_rdata_q;
    assign bus.resp_error_out  = resp_error_q;
    assign bus.apb_addr_out    = addr_q;
    assign bus.apb_psel_out    = psel_q;
    assign bus.apb_penable_out = penable_q;
    assign bus.apb_write_out   = write_q;
    assign bus.apb_wdata_out   = wdata_q;
    assign bus.apb_strb_out    = strb_q;
    assign bus.apb_prot_out    = prot_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master_if
//  Purpose  : Self-checking bench for apb_master_if: directed vector table,
//             back-to-back and mid-transfer reset sequences, and randomized
//             transactions checked against a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_if;

    localparam int TO = 4;

    logic apb_clk;
    logic apb_rstn;

    apb_master_if_if #(.APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32)) bus ();

    apb_master_if #(
        .APB_DATA_WIDTH (32),
        .APB_ADDR_WIDTH (32),
        .TIMEOUT_CYCLE  (TO)
    ) dut (
        .apb_clk_in  (apb_clk),
        .apb_rstn_in (apb_rstn),
        .bus         (bus)
    );

    initial apb_clk = 1'b0;
    always #5 apb_clk = ~apb_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic        slverr;
        logic [31:0] prdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    // Transaction-level reference: a target that withholds PREADY for 'waits'
    // ACCESS cycles either completes or hits the timeout after TO cycles.
    function automatic void model(input logic wr, input int waits, input logic slverr,
                                  input logic [31:0] prdata, output logic err,
                                  output logic [31:0] rd, output int lat);
        if (waits >= TO) begin
            err = 1'b1;
            rd  = 32'h0;
            lat = 2 + TO;
        end else begin
            err = slverr;
            rd  = (!wr && !slverr) ? prdata : 32'h0;
            lat = 2 + waits + 1;
        end
    endfunction

    // Runs one request from an idle post-edge point; acts as the APB target.
    // Outside the completing cycle the target drives misleading PSLVERR/PRDATA.
    task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic [2:0] prot, input int waits, input logic slverr,
                           input logic [31:0] prdata, input logic exp_err,
                           input logic [31:0] exp_rdata, input int exp_lat);
        int   c;
        int   pen_cnt;
        logic got;
        logic [31:0] exp_wd;
        logic [3:0]  exp_sb;
        exp_wd = wr ? wdata : 32'h0;
        exp_sb = wr ? strb  : 4'h0;

        chk({tag, ":req_ready_idle"}, bus.req_ready_out, 1);
        bus.req_valid_in  = 1'b1;
        bus.req_write_in  = wr;
        bus.req_addr_in   = addr;
        bus.req_wdata_in  = wdata;
        bus.req_strb_in   = strb;
        bus.req_prot_in   = prot;
        bus.apb_ready_in  = 1'b0;
        bus.apb_slverr_in = 1'b0;
        @(posedge apb_clk); #1;
        // Scramble request inputs: the bus must hold the captured values.
        bus.req_valid_in  = 1'b0;
        bus.req_addr_in   = $urandom;
        bus.req_wdata_in  = $urandom;
        bus.req_write_in  = ~wr;
        bus.req_strb_in   = 4'($urandom);
        bus.req_prot_in   = 3'($urandom);

        c = 1; pen_cnt = 0; got = 1'b0;
        while (!got && c < 60) begin
            if (bus.resp_valid_out) begin
                got = 1'b1;
                chk({tag, ":latency"},   c, exp_lat);
                chk({tag, ":resp_err"},  bus.resp_error_out, exp_err);
                chk({tag, ":resp_rd"},   bus.resp_rdata_out, exp_rdata);
                chk({tag, ":pen_cyc"},   pen_cnt, exp_lat - 2);
                chk({tag, ":psel_end"},  bus.apb_psel_out, 0);
                chk({tag, ":pen_end"},   bus.apb_penable_out, 0);
                chk({tag, ":ready_end"}, bus.req_ready_out, 1);
            end else begin
                chk({tag, ":psel"},    bus.apb_psel_out, 1);
                chk({tag, ":penable"}, bus.apb_penable_out, (c >= 2) ? 1 : 0);
                chk({tag, ":addr"},    bus.apb_addr_out, addr);
                chk({tag, ":write"},   bus.apb_write_out, wr);
                chk({tag, ":wdata"},   bus.apb_wdata_out, exp_wd);
                chk({tag, ":strb"},    bus.apb_strb_out, exp_sb);
                chk({tag, ":prot"},    bus.apb_prot_out, prot);
                chk({tag, ":rdy_busy"}, bus.req_ready_out, 0);
                if (bus.apb_penable_out) begin
                    pen_cnt++;
                    bus.apb_ready_in  = (pen_cnt - 1 == waits);
                    bus.apb_slverr_in = bus.apb_ready_in ? slverr : 1'b1;
                    bus.apb_rdata_in  = bus.apb_ready_in ? prdata : ~prdata;
                end else begin
                    bus.apb_ready_in  = 1'b1;
                    bus.apb_slverr_in = 1'b1;
                    bus.apb_rdata_in  = ~prdata;
                end
                @(posedge apb_clk); #1;
                c++;
            end
        end
        if (!got) chk({tag, ":resp_timeout"}, 0, 1);
        bus.apb_ready_in  = 1'b0;
        bus.apb_slverr_in = 1'b0;
        // Following idle cycle: single pulse, held response, held bus fields.
        @(posedge apb_clk); #1;
        chk({tag, ":pulse_once"}, bus.resp_valid_out, 0);
        chk({tag, ":err_hold"},   bus.resp_error_out, exp_err);
        chk({tag, ":rd_hold"},    bus.resp_rdata_out, exp_rdata);
        chk({tag, ":addr_hold"},  bus.apb_addr_out, addr);
    endtask

    initial begin
        logic        r_wr, r_slv, m_err;
        logic [31:0] r_addr, r_wd, r_pd, m_rd;
        logic [3:0]  r_sb;
        logic [2:0]  r_pr;
        int          r_wt, m_lat;
        logic [31:0] b2b_addr [3];
        int          acc_cyc [3];
        int          resp_cyc [3];
        int          n_acc, n_resp, idx, cyc;
        logic        accepted;

        vecs[0] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 3'd0, 0,  1'b0, 32'hCAFE_F00D, 1'b0, 32'h0,         3};
        vecs[1] = '{1'b0, 32'h0000_0080, 32'h1111_1111, 4'hF, 3'd2, 2,  1'b0, 32'h1234_5678, 1'b0, 32'h1234_5678, 5};
        vecs[2] = '{1'b0, 32'h0000_0084, 32'h0,         4'h0, 3'd0, 0,  1'b1, 32'hA5A5_A5A5, 1'b1, 32'h0,         3};
        vecs[3] = '{1'b0, 32'h0000_0088, 32'h0,         4'h0, 3'd1, 1,  1'b0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 4};
        vecs[4] = '{1'b0, 32'h0000_008C, 32'h0,         4'h0, 3'd0, 10, 1'b0, 32'h55AA_55AA, 1'b1, 32'h0,         6};
        vecs[5] = '{1'b0, 32'h0000_0090, 32'h0,         4'h0, 3'd4, 3,  1'b0, 32'h600D_CAFE, 1'b0, 32'h600D_CAFE, 6};
        vecs[6] = '{1'b1, 32'h0000_0094, 32'h0123_4567, 4'h5, 3'd7, 3,  1'b1, 32'h7777_7777, 1'b1, 32'h0,         6};
        vecs[7] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h3, 3'd3, 4,  1'b0, 32'h9999_9999, 1'b1, 32'h0,         6};

        apb_rstn          = 1'b0;
        bus.req_valid_in  = 1'b0;
        bus.req_addr_in   = '0;
        bus.req_write_in  = 1'b0;
        bus.req_wdata_in  = '0;
        bus.req_strb_in   = '0;
        bus.req_prot_in   = '0;
        bus.apb_rdata_in  = '0;
        bus.apb_ready_in  = 1'b0;
        bus.apb_slverr_in = 1'b0;

        repeat (3) @(posedge apb_clk);
        #1;
        chk("rst:psel",       bus.apb_psel_out, 0);
        chk("rst:penable",    bus.apb_penable_out, 0);
        chk("rst:resp_valid", bus.resp_valid_out, 0);
        chk("rst:resp_rdata", bus.resp_rdata_out, 0);
        chk("rst:resp_error", bus.resp_error_out, 0);
        chk("rst:addr",       bus.apb_addr_out, 0);
        chk("rst:wdata",      bus.apb_wdata_out, 0);
        chk("rst:req_ready",  bus.req_ready_out, 1);
        apb_rstn = 1'b1;
        @(posedge apb_clk); #1;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].strb, vecs[i].prot, vecs[i].waits, vecs[i].slverr,
                    vecs[i].prdata, vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_lat);
        end

        // Back-to-back writes with req_valid held high
        b2b_addr[0] = 32'h0000_1000;
        b2b_addr[1] = 32'h0000_2004;
        b2b_addr[2] = 32'h0000_3008;
        for (int k = 0; k < 3; k++) begin
            acc_cyc[k]  = -1;
            resp_cyc[k] = -1;
        end
        n_acc = 0; n_resp = 0; idx = 0; cyc = 0;
        bus.apb_ready_in  = 1'b1;
        bus.apb_slverr_in = 1'b0;
        bus.req_valid_in  = 1'b1;
        bus.req_write_in  = 1'b1;
        bus.req_addr_in   = b2b_addr[0];
        bus.req_wdata_in  = 32'hA000_0000;
        bus.req_strb_in   = 4'hF;
        bus.req_prot_in   = 3'd0;
        while (n_resp < 3 && cyc < 40) begin
            if (bus.resp_valid_out) begin
                chk($sformatf("b2b%0d:err", n_resp), bus.resp_error_out, 0);
                chk($sformatf("b2b%0d:rd", n_resp),  bus.resp_rdata_out, 0);
                resp_cyc[n_resp] = cyc;
                n_resp++;
            end
            accepted = bus.req_valid_in && bus.req_ready_out;
            if (accepted && n_acc < 3) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            @(posedge apb_clk); #1;
            cyc++;
            if (accepted && idx < 3) begin
                chk($sformatf("b2b%0d:psel", idx),  bus.apb_psel_out, 1);
                chk($sformatf("b2b%0d:pen", idx),   bus.apb_penable_out, 0);
                chk($sformatf("b2b%0d:addr", idx),  bus.apb_addr_out, b2b_addr[idx]);
                idx++;
                if (idx < 3) begin
                    bus.req_addr_in  = b2b_addr[idx];
                    bus.req_wdata_in = 32'hA000_0000 + 32'(idx);
                end else begin
                    bus.req_valid_in = 1'b0;
                end
            end
        end
        bus.req_valid_in = 1'b0;
        bus.apb_ready_in = 1'b0;
        chk("b2b:n_resp", n_resp, 3);
        chk("b2b:n_acc",  n_acc, 3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("b2b%0d:lat", k), resp_cyc[k] - acc_cyc[k], 3);
        for (int k = 0; k < 2; k++)
            chk($sformatf("b2b%0d:acc_on_resp", k), acc_cyc[k + 1], resp_cyc[k]);
        @(posedge apb_clk); #1;

        // Reset asserted during ACCESS
        bus.req_valid_in = 1'b1;
        bus.req_write_in = 1'b1;
        bus.req_addr_in  = 32'h0000_0100;
        bus.req_wdata_in = 32'hFEED_FACE;
        bus.req_strb_in  = 4'hF;
        bus.req_prot_in  = 3'd5;
        bus.apb_ready_in = 1'b0;
        @(posedge apb_clk); #1;
        bus.req_valid_in = 1'b0;
        @(posedge apb_clk); #1;
        chk("mrst:pen_before", bus.apb_penable_out, 1);
        @(posedge apb_clk); #3;
        apb_rstn = 1'b0;
        #1;
        chk("mrst:psel",   bus.apb_psel_out, 0);
        chk("mrst:pen",    bus.apb_penable_out, 0);
        chk("mrst:addr",   bus.apb_addr_out, 0);
        chk("mrst:wdata",  bus.apb_wdata_out, 0);
        chk("mrst:write",  bus.apb_write_out, 0);
        chk("mrst:prot",   bus.apb_prot_out, 0);
        chk("mrst:rvalid", bus.resp_valid_out, 0);
        chk("mrst:rerr",   bus.resp_error_out, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge apb_clk); #1;
            chk("mrst:no_resp", bus.resp_valid_out, 0);
        end
        apb_rstn = 1'b1;
        @(posedge apb_clk); #1;
        chk("mrst:no_resp_after", bus.resp_valid_out, 0);
        run_txn("post_rst", 1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'd0, 1, 1'b0,
                32'hBEEF_0001, 1'b0, 32'hBEEF_0001, 4);

        // Randomized transactions against the reference model
        for (int i = 0; i < 40; i++) begin
            r_wr   = 1'($urandom);
            r_addr = $urandom;
            r_wd   = $urandom;
            r_sb   = 4'($urandom_range(0, 15));
            r_pr   = 3'($urandom_range(0, 7));
            r_wt   = $urandom_range(0, 6);
            r_slv  = ($urandom_range(0, 3) == 0);
            r_pd   = $urandom;
            model(r_wr, r_wt, r_slv, r_pd, m_err, m_rd, m_lat);
            run_txn($sformatf("rnd%0d", i), r_wr, r_addr, r_wd, r_sb, r_pr, r_wt,
                    r_slv, r_pd, m_err, m_rd, m_lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
